id_ex_stage: RTL and testbench

//  Decode/execute boundary register that drives the 32-bit ALU's operation/operand1/operand2 inputs.

---
 rtl/id_ex_pkg.sv | 57 +++++
 rtl/id_ex_stage_if.sv | 76 +++++++
 rtl/id_ex_stage_alu_op_decoder.sv | 109 ++++++++++
 rtl/id_ex_stage.sv | 167 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_pkg
// Shared constants and types for the decode/execute boundary stage:
//   - RV32 opcode and funct3/funct7 encodings the stage understands
//   - 3-bit ALU operation codes driven into the 32-bit ALU
//   - occupancy FSM states and the decoder result bundle
// ---------------------------------------------------------------------------
package id_ex_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct7 variants (instr[31:25])
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // funct3 values (instr[14:12])
  localparam logic [2:0] F3_ADD = 3'b000;  // ADD/SUB/MUL/ADDI/BEQ
  localparam logic [2:0] F3_SLL = 3'b001;  // SLL/SLLI/BNE
  localparam logic [2:0] F3_DIV = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;  // SRL/SRA/SRLI/SRAI

  // Shift amount width seen by the ALU
  localparam int SHAMT_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_MUL = 3'b010,
    ALU_DIV = 3'b011,
    ALU_SHL = 3'b100,
    ALU_SHR = 3'b101
  } alu_op_e;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } occ_state_e;

  typedef struct packed {
    alu_op_e op;
    logic    use_imm;
    logic    is_branch;
    logic    reg_write;
    logic    illegal;
  } decode_t;

  function automatic logic is_shift_op(input alu_op_e op);
    return (op == ALU_SHL) || (op == ALU_SHR);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundle of every non-clock/reset signal of id_ex_stage.
//   master : decode side, hazard sources and downstream consumer (drives inputs)
//   slave  : the id_ex_stage itself
// Groups: decode handshake + instruction fields, EX/MEM and MEM/WB forwarding
// sources, flush, EX handshake, ALU-facing outputs and perf counters.
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) ();

  // Decode side
  logic                  id_valid;
  logic                  id_ready;
  logic [XLEN-1:0]       id_pc;
  logic [6:0]            id_opcode;
  logic [2:0]            id_funct3;
  logic [6:0]            id_funct7;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic [REG_ADDR_W-1:0] id_rd_addr;

  // Forwarding sources
  logic                  exmem_reg_write;
  logic [REG_ADDR_W-1:0] exmem_rd_addr;
  logic [XLEN-1:0]       exmem_result;
  logic                  memwb_reg_write;
  logic [REG_ADDR_W-1:0] memwb_rd_addr;
  logic [XLEN-1:0]       memwb_result;

  // Control
  logic                  flush;
  logic                  ex_ready;

  // Execute side
  logic                  ex_valid;
  logic [2:0]            alu_operation;
  logic [XLEN-1:0]       alu_operand1;
  logic [XLEN-1:0]       alu_operand2;
  logic [XLEN-1:0]       ex_store_data;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_reg_write;
  logic                  ex_is_branch;
  logic                  ex_illegal;
  logic [XLEN-1:0]       ex_pc;
  logic [31:0]           perf_stall_cnt;
  logic [31:0]           perf_flush_cnt;

  modport master (
    output id_valid, id_pc, id_opcode, id_funct3, id_funct7,
           id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm, id_rd_addr,
           exmem_reg_write, exmem_rd_addr, exmem_result,
           memwb_reg_write, memwb_rd_addr, memwb_result,
           flush, ex_ready,
    input  id_ready, ex_valid, alu_operation, alu_operand1, alu_operand2,
           ex_store_data, ex_rd_addr, ex_reg_write, ex_is_branch, ex_illegal,
           ex_pc, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_opcode, id_funct3, id_funct7,
           id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm, id_rd_addr,
           exmem_reg_write, exmem_rd_addr, exmem_result,
           memwb_reg_write, memwb_rd_addr, memwb_result,
           flush, ex_ready,
    output id_ready, ex_valid, alu_operation, alu_operand1, alu_operand2,
           ex_store_data, ex_rd_addr, ex_reg_write, ex_is_branch, ex_illegal,
           ex_pc, perf_stall_cnt, perf_flush_cnt
  );

endinterface

// File: rtl/id_ex_stage_alu_op_decoder.sv
// ---------------------------------------------------------------------------
// alu_op_decoder
// Purely combinational translation of an RV32 opcode/funct3/funct7 triple to
// the ALU operation plus operand/writeback attributes.
// Ports:
//   opcode_i  in  7   instr[6:0]
//   funct3_i  in  3   instr[14:12]
//   funct7_i  in  7   instr[31:25]
//   dec_o     out     {op, use_imm, is_branch, reg_write, illegal}
// Anything not explicitly recognised (including SRA/SRAI) is reported as
// illegal with op=ADD, no writeback and no branch.
// ---------------------------------------------------------------------------
module alu_op_decoder
  import id_ex_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output decode_t    dec_o
);

  alu_op_e op;
  logic    use_imm;
  logic    is_branch;
  logic    writes;
  logic    legal;

  always_comb begin
    op        = ALU_ADD;
    use_imm   = 1'b1;
    is_branch = 1'b0;
    writes    = 1'b0;
    legal     = 1'b0;
    case (opcode_i)
      OP_R: begin
        use_imm = 1'b0;
        writes  = 1'b1;
        case (funct7_i)
          F7_MULDIV: begin
            if (funct3_i == F3_ADD) begin
              op    = ALU_MUL;
              legal = 1'b1;
            end else if (funct3_i == F3_DIV) begin
              op    = ALU_DIV;
              legal = 1'b1;
            end
          end
          F7_BASE: begin
            case (funct3_i)
              F3_ADD:  begin op = ALU_ADD; legal = 1'b1; end
              F3_SLL:  begin op = ALU_SHL; legal = 1'b1; end
              F3_SRL:  begin op = ALU_SHR; legal = 1'b1; end
              default: ;
            endcase
          end
          F7_ALT: begin
            // Only SUB; SRA shares this funct7 and is deliberately rejected
            if (funct3_i == F3_ADD) begin
              op    = ALU_SUB;
              legal = 1'b1;
            end
          end
          default: ;
        endcase
      end
      OP_I: begin
        writes = 1'b1;
        case (funct3_i)
          F3_ADD: begin op = ALU_ADD; legal = 1'b1; end
          F3_SLL: begin op = ALU_SHL; legal = 1'b1; end
          F3_SRL: begin
            // SRAI (funct7=0100000) is not supported
            if (funct7_i == F7_BASE) begin
              op    = ALU_SHR;
              legal = 1'b1;
            end
          end
          default: ;
        endcase
      end
      OP_LOAD: begin
        writes = 1'b1;
        legal  = 1'b1;
      end
      OP_STORE: begin
        legal = 1'b1;
      end
      OP_BRANCH: begin
        use_imm = 1'b0;
        if ((funct3_i == F3_ADD) || (funct3_i == F3_SLL)) begin
          op        = ALU_SUB;
          is_branch = 1'b1;
          legal     = 1'b1;
        end
      end
      default: ;
    endcase

    if (!legal) begin
      op        = ALU_ADD;
      is_branch = 1'b0;
      writes    = 1'b0;
    end
  end

  assign dec_o = '{op: op, use_imm: use_imm, is_branch: is_branch,
                   reg_write: writes, illegal: !legal};

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// Decode/execute pipeline register feeding the 32-bit ALU. Captures one
// decoded RV32 instruction under a valid/ready handshake, decodes it to a
// 3-bit ALU code, resolves rs1/rs2 forwarding from EX/MEM and MEM/WB at
// capture time and selects operand2 (rs2 or immediate).
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   synchronous active-high reset
//   bus    slave modport of id_ex_stage_if (decode handshake + fields,
//          forwarding sources, flush, EX handshake, ALU outputs, perf counters)
// Build option: define ID_EX_PERF_CNT_EN to build the saturating stall/flush
// counters; otherwise both perf outputs read 0.
// ---------------------------------------------------------------------------
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    alu_op_e               op;
    logic [XLEN-1:0]       op1;
    logic [XLEN-1:0]       op2;
    logic [XLEN-1:0]       store;
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_branch;
    logic                  illegal;
  } payload_t;

  occ_state_e state_q;
  payload_t   payload_q;
  payload_t   payload_d;
  decode_t    dec;

  logic ex_valid;
  logic id_ready;
  logic capture;

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  alu_op_decoder u_dec (
    .opcode_i (bus.id_opcode),
    .funct3_i (bus.id_funct3),
    .funct7_i (bus.id_funct7),
    .dec_o    (dec)
  );

  // -------------------------------------------------------------------------
  // Forwarding: index 0 = rs1, index 1 = rs2. EX/MEM is younger, so it wins.
  // -------------------------------------------------------------------------
  logic [REG_ADDR_W-1:0] rs_addr  [2];
  logic [XLEN-1:0]       rs_data  [2];
  logic [XLEN-1:0]       fwd_data [2];

  assign rs_addr[0] = bus.id_rs1_addr;
  assign rs_addr[1] = bus.id_rs2_addr;
  assign rs_data[0] = bus.id_rs1_data;
  assign rs_data[1] = bus.id_rs2_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic exmem_hit;
      logic memwb_hit;
      assign exmem_hit = bus.exmem_reg_write && (bus.exmem_rd_addr == rs_addr[gi]) &&
                         (bus.exmem_rd_addr != '0);
      assign memwb_hit = bus.memwb_reg_write && (bus.memwb_rd_addr == rs_addr[gi]) &&
                         (bus.memwb_rd_addr != '0);
      assign fwd_data[gi] = exmem_hit ? bus.exmem_result :
                            memwb_hit ? bus.memwb_result : rs_data[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Operand selection and next payload
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] src2;
  assign src2 = dec.use_imm ? bus.id_imm : fwd_data[1];

  always_comb begin
    payload_d           = '0;
    payload_d.op        = dec.op;
    payload_d.op1       = fwd_data[0];
    // Shifts only ever see a 5-bit amount, zero-extended
    payload_d.op2       = is_shift_op(dec.op) ? {{(XLEN-SHAMT_W){1'b0}}, src2[SHAMT_W-1:0]}
                                              : src2;
    payload_d.store     = fwd_data[1];
    payload_d.pc        = bus.id_pc;
    payload_d.rd        = bus.id_rd_addr;
    payload_d.reg_write = dec.reg_write && (bus.id_rd_addr != '0);
    payload_d.is_branch = dec.is_branch;
    payload_d.illegal   = dec.illegal;
  end

  // -------------------------------------------------------------------------
  // Occupancy FSM + pipeline register
  // -------------------------------------------------------------------------
  assign ex_valid = (state_q == S_FULL);
  assign id_ready = !ex_valid || bus.ex_ready;
  assign capture  = bus.id_valid && id_ready && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_EMPTY;
      payload_q <= '0;
    end else if (bus.flush) begin
      // Payload is left as-is; only the valid bit matters after a squash
      state_q <= S_EMPTY;
    end else if (capture) begin
      state_q   <= S_FULL;
      payload_q <= payload_d;
    end else if (ex_valid && bus.ex_ready) begin
      state_q <= S_EMPTY;
    end
  end

  assign bus.id_ready      = id_ready;
  assign bus.ex_valid      = ex_valid;
  assign bus.alu_operation = payload_q.op;
  assign bus.alu_operand1  = payload_q.op1;
  assign bus.alu_operand2  = payload_q.op2;
  assign bus.ex_store_data = payload_q.store;
  assign bus.ex_pc         = payload_q.pc;
  assign bus.ex_rd_addr    = payload_q.rd;
  assign bus.ex_reg_write  = payload_q.reg_write;
  assign bus.ex_is_branch  = payload_q.is_branch;
  assign bus.ex_illegal    = payload_q.illegal;

  // -------------------------------------------------------------------------
  // Performance counters (saturating)
  // -------------------------------------------------------------------------
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ex_valid && !bus.ex_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      // A flush only counts when it actually kills the held instruction
      if (bus.flush && ex_valid && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign bus.perf_stall_cnt = stall_cnt_q;
  assign bus.perf_flush_cnt = flush_cnt_q;
`else
  assign bus.perf_stall_cnt = 32'd0;
  assign bus.perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed scenarios with literal expectations followed by randomized
// traffic, all checked every cycle against a table-driven reference model.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
  import id_ex_pkg::*;

  logic clk;
  logic reset;

  id_ex_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%08h want=%08h t=%0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [6:0] opc;
    logic       f3_any;
    logic [2:0] f3;
    logic       f7_any;
    logic [6:0] f7;
    logic [2:0] op;
    logic       w;
    logic       br;
  } rule_t;

  rule_t rules [14];

  initial begin
    rules[0]  = '{OP_R,      0, 3'b000, 0, 7'h01, 3'd2, 1, 0};
    rules[1]  = '{OP_R,      0, 3'b100, 0, 7'h01, 3'd3, 1, 0};
    rules[2]  = '{OP_R,      0, 3'b000, 0, 7'h00, 3'd0, 1, 0};
    rules[3]  = '{OP_R,      0, 3'b001, 0, 7'h00, 3'd4, 1, 0};
    rules[4]  = '{OP_R,      0, 3'b101, 0, 7'h00, 3'd5, 1, 0};
    rules[5]  = '{OP_R,      0, 3'b000, 0, 7'h20, 3'd1, 1, 0};
    rules[6]  = '{OP_I,      0, 3'b000, 1, 7'h00, 3'd0, 1, 0};
    rules[7]  = '{OP_I,      0, 3'b001, 1, 7'h00, 3'd4, 1, 0};
    rules[8]  = '{OP_I,      0, 3'b101, 0, 7'h00, 3'd5, 1, 0};
    rules[9]  = '{OP_LOAD,   1, 3'b000, 1, 7'h00, 3'd0, 1, 0};
    rules[10] = '{OP_STORE,  1, 3'b000, 1, 7'h00, 3'd0, 0, 0};
    rules[11] = '{OP_BRANCH, 0, 3'b000, 1, 7'h00, 3'd1, 0, 1};
    rules[12] = '{OP_BRANCH, 0, 3'b001, 1, 7'h00, 3'd1, 0, 1};
    rules[13] = rules[12];
  end

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] store;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic        ill;
  } exp_t;

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
    if (a != 0 && bus.exmem_reg_write && bus.exmem_rd_addr == a) return bus.exmem_result;
    if (a != 0 && bus.memwb_reg_write && bus.memwb_rd_addr == a) return bus.memwb_result;
    return rf;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic found;
    logic [31:0] a, b, s2;
    e = '0;
    found = 0;
    for (int i = 0; i < 14; i++) begin
      if (!found && rules[i].opc == bus.id_opcode &&
          (rules[i].f3_any || rules[i].f3 == bus.id_funct3) &&
          (rules[i].f7_any || rules[i].f7 == bus.id_funct7)) begin
        found = 1;
        e.op = rules[i].op;
        e.we = rules[i].w;
        e.br = rules[i].br;
      end
    end
    e.ill = !found;
    a = fwd(bus.id_rs1_addr, bus.id_rs1_data);
    b = fwd(bus.id_rs2_addr, bus.id_rs2_data);
    s2 = (bus.id_opcode == OP_R || bus.id_opcode == OP_BRANCH) ? b : bus.id_imm;
    if (e.op == 3'd4 || e.op == 3'd5) s2 = s2 % 32;
    e.op1 = a;
    e.op2 = s2;
    e.store = b;
    e.pc = bus.id_pc;
    e.rd = bus.id_rd_addr;
    e.we = e.we && (bus.id_rd_addr != 0);
    return e;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  logic        m_init = 0;
  logic        m_valid = 0;
  exp_t        m_exp = '0;
  logic [31:0] m_stall = 0;
  logic [31:0] m_flush = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_init  <= 1;
      m_valid <= 0;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
`ifdef ID_EX_PERF_CNT_EN
      if (m_valid && !bus.ex_ready) m_stall <= sat_inc(m_stall);
      if (bus.flush && m_valid) m_flush <= sat_inc(m_flush);
`endif
      if (bus.flush) m_valid <= 0;
      else if (bus.id_valid && (!m_valid || bus.ex_ready)) begin
        m_valid <= 1;
        m_exp   <= predict();
        $display("capture pc=%08h opc=%07b f3=%03b f7=%07b rd=%0d", bus.id_pc,
                 bus.id_opcode, bus.id_funct3, bus.id_funct7, bus.id_rd_addr);
      end else if (bus.ex_ready) m_valid <= 0;
    end
  end

  // Single compare process, mid-cycle
  always @(negedge clk) begin
    if (m_init) begin
      chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m_valid});
      chk("id_ready", {31'd0, bus.id_ready}, {31'd0, (!m_valid || bus.ex_ready)});
      if (m_valid) begin
        chk("alu_op",   {29'd0, bus.alu_operation}, {29'd0, m_exp.op});
        chk("operand1", bus.alu_operand1, m_exp.op1);
        chk("operand2", bus.alu_operand2, m_exp.op2);
        chk("store",    bus.ex_store_data, m_exp.store);
        chk("pc",       bus.ex_pc, m_exp.pc);
        chk("rd",       {27'd0, bus.ex_rd_addr}, {27'd0, m_exp.rd});
        chk("reg_write", {31'd0, bus.ex_reg_write}, {31'd0, m_exp.we});
        chk("branch",   {31'd0, bus.ex_is_branch}, {31'd0, m_exp.br});
        chk("illegal",  {31'd0, bus.ex_illegal}, {31'd0, m_exp.ill});
      end
      chk("perf_stall", bus.perf_stall_cnt, m_stall);
      chk("perf_flush", bus.perf_flush_cnt, m_flush);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_opcode = 0; bus.id_funct3 = 0;
    bus.id_funct7 = 0; bus.id_rs1_addr = 0; bus.id_rs2_addr = 0;
    bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_rd_addr = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd_addr = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd_addr = 0; bus.memwb_result = 0;
    bus.flush = 0; bus.ex_ready = 1;
  endtask

  task automatic instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [31:0] pc);
    bus.id_valid = 1; bus.id_opcode = opc; bus.id_funct3 = f3; bus.id_funct7 = f7;
    bus.id_rs1_addr = rs1; bus.id_rs2_addr = rs2; bus.id_rd_addr = rd;
    bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm; bus.id_pc = pc;
  endtask

  logic [6:0] opc_pick;
  logic [6:0] f7_pick;

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    // Reset state
    chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_id_ready", {31'd0, bus.id_ready}, 32'd1);
    chk("rst_op",       {29'd0, bus.alu_operation}, 32'd0);
    chk("rst_operand1", bus.alu_operand1, 32'd0);
    chk("rst_operand2", bus.alu_operand2, 32'd0);
    chk("rst_pc",       bus.ex_pc, 32'd0);
    chk("rst_rd",       {27'd0, bus.ex_rd_addr}, 32'd0);
    chk("rst_stall",    bus.perf_stall_cnt, 32'd0);
    chk("rst_flush",    bus.perf_flush_cnt, 32'd0);
    reset = 0;

    // ADD x3,x1,x2 captured, then held while ex_ready=0
    instr(OP_R, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'h100);
    bus.ex_ready = 0;
    tick();
    chk("add_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("add_op",    {29'd0, bus.alu_operation}, 32'd0);
    chk("add_op1",   bus.alu_operand1, 32'd5);
    chk("add_op2",   bus.alu_operand2, 32'd7);
    chk("add_rd",    {27'd0, bus.ex_rd_addr}, 32'd3);
    bus.id_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_id_ready", {31'd0, bus.id_ready}, 32'd0);
      chk("stall_op1",      bus.alu_operand1, 32'd5);
      chk("stall_op2",      bus.alu_operand2, 32'd7);
      tick();
    end
`ifdef ID_EX_PERF_CNT_EN
    chk("stall_cnt", bus.perf_stall_cnt, 32'd3);
`else
    chk("stall_cnt", bus.perf_stall_cnt, 32'd0);
`endif
    bus.ex_ready = 1;
    tick();
    chk("drain_valid", {31'd0, bus.ex_valid}, 32'd0);

    // Forwarding
    instr(OP_R, 3'b000, 7'h00, 5'd4, 5'd0, 5'd5, 32'h11, 32'd0, 32'd0, 32'h104);
    bus.exmem_reg_write = 1; bus.exmem_rd_addr = 4; bus.exmem_result = 32'hAA;
    bus.memwb_reg_write = 1; bus.memwb_rd_addr = 4; bus.memwb_result = 32'hBB;
    tick();
    chk("fwd_exmem", bus.alu_operand1, 32'hAA);
    bus.exmem_reg_write = 0;
    tick();
    chk("fwd_memwb", bus.alu_operand1, 32'hBB);
    bus.exmem_reg_write = 1; bus.exmem_rd_addr = 0;
    bus.memwb_rd_addr = 0; bus.id_rs1_addr = 0;
    tick();
    chk("fwd_x0", bus.alu_operand1, 32'h11);
    bus.id_rs2_addr = 6; bus.exmem_rd_addr = 6; bus.exmem_result = 32'hCC;
    tick();
    chk("fwd_rs2_op2",   bus.alu_operand2, 32'hCC);
    chk("fwd_rs2_store", bus.ex_store_data, 32'hCC);
    idle();
    tick();

    // Back-to-back
    for (int i = 0; i < 4; i++) begin
      instr(OP_R, 3'b000, 7'h00, 5'd1, 5'd2, 5'(10 + i), 32'd1, 32'd2, 32'd0, 32'h200 + 4 * i);
      tick();
      chk("b2b_valid", {31'd0, bus.ex_valid}, 32'd1);
      chk("b2b_rd",    {27'd0, bus.ex_rd_addr}, 10 + i);
    end
    idle();
    tick();
    chk("b2b_drain", {31'd0, bus.ex_valid}, 32'd0);

    // Flush while FULL, with a new instruction offered
    instr(OP_R, 3'b000, 7'h00, 5'd1, 5'd2, 5'd7, 32'd1, 32'd2, 32'd0, 32'h300);
    bus.ex_ready = 0;
    tick();
    chk("pre_flush_valid", {31'd0, bus.ex_valid}, 32'd1);
    bus.id_rd_addr = 8; bus.flush = 1;
    tick();
    chk("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
    chk("flush_cnt", bus.perf_flush_cnt, 32'd1);
`else
    chk("flush_cnt", bus.perf_flush_cnt, 32'd0);
`endif
    idle();

    // Decode cases
    instr(OP_R, 3'b000, 7'h01, 5'd1, 5'd2, 5'd9, 32'd3, 32'd4, 32'd0, 32'h400);
    tick();
    chk("mul_op", {29'd0, bus.alu_operation}, 32'd2);
    instr(OP_I, 3'b001, 7'h00, 5'd1, 5'd0, 5'd9, 32'd9, 32'd0, 32'h23, 32'h404);
    tick();
    chk("slli_op",  {29'd0, bus.alu_operation}, 32'd4);
    chk("slli_op2", bus.alu_operand2, 32'd3);
    instr(OP_R, 3'b101, 7'h20, 5'd1, 5'd2, 5'd9, 32'd9, 32'd1, 32'd0, 32'h408);
    tick();
    chk("sra_illegal", {31'd0, bus.ex_illegal}, 32'd1);
    chk("sra_op",      {29'd0, bus.alu_operation}, 32'd0);
    chk("sra_we",      {31'd0, bus.ex_reg_write}, 32'd0);
    instr(OP_BRANCH, 3'b000, 7'h00, 5'd1, 5'd2, 5'd0, 32'd5, 32'd5, 32'h10, 32'h40C);
    tick();
    chk("beq_op",     {29'd0, bus.alu_operation}, 32'd1);
    chk("beq_branch", {31'd0, bus.ex_is_branch}, 32'd1);
    chk("beq_op2",    bus.alu_operand2, 32'd5);
    instr(OP_LOAD, 3'b010, 7'h00, 5'd1, 5'd0, 5'd0, 32'h100, 32'd0, 32'h8, 32'h410);
    tick();
    chk("load_x0_we", {31'd0, bus.ex_reg_write}, 32'd0);
    chk("load_op2",   bus.alu_operand2, 32'h8);
    idle();
    tick();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      case ($urandom_range(0, 6))
        0, 6: opc_pick = OP_R;
        1: opc_pick = OP_I;
        2: opc_pick = OP_LOAD;
        3: opc_pick = OP_STORE;
        4: opc_pick = OP_BRANCH;
        default: opc_pick = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: f7_pick = F7_BASE;
        1: f7_pick = F7_ALT;
        2: f7_pick = F7_MULDIV;
        default: f7_pick = 7'($urandom);
      endcase
      instr(opc_pick, 3'($urandom), f7_pick, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom, $urandom);
      bus.id_valid        = ($urandom_range(0, 3) != 0);
      bus.exmem_reg_write = 1'($urandom);
      bus.exmem_rd_addr   = 5'($urandom_range(0, 7));
      bus.exmem_result    = $urandom;
      bus.memwb_reg_write = 1'($urandom);
      bus.memwb_rd_addr   = 5'($urandom_range(0, 7));
      bus.memwb_result    = $urandom;
      bus.flush           = ($urandom_range(0, 11) == 0);
      bus.ex_ready        = ($urandom_range(0, 2) != 0);
      tick();
    end
    reset = 0;
    idle();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
